// File: rtl/led_blinker_bank.sv
// Bank of NCHAN independent LED drivers, each with a programmable half-period
// and one of four modes: OFF, ON, free-running BLINK, or a counted BURST.
module led_blinker_bank #(
    parameter int NCHAN        = 4,
    parameter int CNT_W        = 27,
`ifdef SIMULATION
    parameter int DEFAULT_HALF = 50,
`else
    parameter int DEFAULT_HALF = 50000000,
`endif
    localparam int CHAN_W      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [7:0]        cfg_count,
    output logic [NCHAN-1:0]  led,
    output logic [NCHAN-1:0]  busy,
    output logic [NCHAN-1:0]  burst_done
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        mode_t            mode_q, mode_d;
        logic [CNT_W-1:0] half_q, half_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [7:0]       rem_q, rem_d;
        logic             led_q, led_d;
        logic             busy_q, busy_d;
        logic             done_q, done_d;
        logic             sel;
        logic             wrap;
        mode_t            wr_mode;

        // Out-of-range channel numbers match no instance, so such writes are dropped.
        assign sel     = cfg_we && (cfg_chan == CHAN_W'(i));
        assign wrap    = (cnt_q == half_q - ONE);
        assign wr_mode = mode_t'(cfg_mode);

        always_comb begin
            // NOTE: every output of this block is defaulted first so no latch is inferred.
            mode_d = mode_q;
            half_d = half_q;
            cnt_d  = cnt_q;
            rem_d  = rem_q;
            led_d  = led_q;
            busy_d = busy_q;
            done_d = 1'b0;

            if (sel) begin
                // A write overrides any toggle or completion due in the same cycle.
                mode_d = wr_mode;
                half_d = (cfg_half == '0) ? ONE : cfg_half;
                cnt_d  = '0;
                led_d  = (wr_mode == MODE_ON);
                rem_d  = '0;
                busy_d = 1'b0;
                if (wr_mode == MODE_BURST) begin
                    if (cfg_count == 8'd0) begin
                        mode_d = MODE_OFF;
                        done_d = 1'b1;
                    end else begin
                        rem_d  = cfg_count;
                        busy_d = 1'b1;
                    end
                end
            end else begin
                unique case (mode_q)
                    MODE_OFF: begin
                        led_d = 1'b0;
                        cnt_d = '0;
                    end
                    MODE_ON: begin
                        led_d = 1'b1;
                        cnt_d = '0;
                    end
                    MODE_BLINK, MODE_BURST: begin
                        if (wrap) begin
                            cnt_d = '0;
                            led_d = ~led_q;
                            // Only falling toggles consume a burst pulse.
                            if (mode_q == MODE_BURST && led_q) begin
                                rem_d = rem_q - 8'd1;
                                if (rem_q == 8'd1) begin
                                    mode_d = MODE_OFF;
                                    busy_d = 1'b0;
                                    done_d = 1'b1;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                mode_q <= MODE_BLINK;
                half_q <= HALF_RST;
                cnt_q  <= '0;
                rem_q  <= '0;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                mode_q <= mode_d;
                half_q <= half_d;
                cnt_q  <= cnt_d;
                rem_q  <= rem_d;
                led_q  <= led_d;
                busy_q <= busy_d;
                done_q <= done_d;
            end
        end

        assign led[i]        = led_q;
        assign busy[i]       = busy_q;
        assign burst_done[i] = done_q;
    end

endmodule
